pll_lock_ctrl: RTL

- Supervisor/sequencer for the soft PLL (pll_sft).
- After reset: drives pll_rst, waits for a stable lock, then monitors lock continuously.
- Applies runtime output-divider/duty changes (dyn_odiv0/dyn_duty0) by sequencing a PLL re-reset and relock.
- Runs on a free-running board clock that is not derived from the PLL; flags persistent lock failure to system logic.

---
 rtl/pll_lock_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_ctrl.sv
// Soft-PLL supervisor: reset/lock sequencing, lock monitoring, runtime divider/duty reconfiguration.
// Latency: pll_lock seen 2 cycles after change; lock qualified after LOCK_STABLE synced-high cycles.
// Backpressure: cfg_busy high outside LOCKED/FAIL, requests then dropped. Option PLL_LOCK_CTRL_PWD_EN adds pll_pwd.
module pll_lock_ctrl #(
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 64,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         MAX_RETRY    = 3,
    parameter logic [9:0] DEF_ODIV     = 10'd100,
    parameter logic [9:0] DEF_DUTY     = 10'd100
`ifdef PLL_LOCK_CTRL_PWD_EN
    ,
    parameter int         PWD_CYCLES   = 16
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       cfg_req,
    input  logic [9:0] cfg_odiv,
    input  logic [9:0] cfg_duty,
    output logic       pll_rst,
    output logic [9:0] dyn_odiv0,
    output logic [9:0] dyn_duty0,
    output logic       ctrl_locked,
    output logic       cfg_busy,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic       lock_fail,
    output logic [7:0] relock_cnt
`ifdef PLL_LOCK_CTRL_PWD_EN
    ,
    output logic       pll_pwd
`endif
);

    localparam logic [2:0] RST_ASSERT = 3'd0;
    localparam logic [2:0] WAIT_LOCK  = 3'd1;
    localparam logic [2:0] LOCKED     = 3'd2;
    localparam logic [2:0] APPLY      = 3'd3;
    localparam logic [2:0] FAIL       = 3'd4;
`ifdef PLL_LOCK_CTRL_PWD_EN
    localparam logic [2:0] PWD        = 3'd5;
    localparam logic [2:0] INIT_STATE = PWD;
    localparam int         PW_W       = (PWD_CYCLES > 1) ? $clog2(PWD_CYCLES) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWD_CYCLES - 1);
`else
    localparam logic [2:0] INIT_STATE = RST_ASSERT;
`endif

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SC_W = $clog2(LOCK_STABLE + 1);
    localparam int TC_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_DONE = SC_W'(LOCK_STABLE);
    localparam logic [TC_W-1:0] TC_DONE = TC_W'(LOCK_TIMEOUT);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    logic [2:0]      state, state_nxt;
    logic [1:0]      lock_sync;
    logic            lock_s;
    logic [RC_W-1:0] rst_cnt, rst_cnt_nxt;
    logic [SC_W-1:0] stable_cnt, stable_nxt;
    logic [TC_W-1:0] tmo_cnt, tmo_nxt;
    logic [RT_W-1:0] retry_cnt, retry_nxt;
    logic [7:0]      relock_nxt;
    logic [9:0]      odiv_nxt, duty_nxt;
    logic            err_nxt, pll_rst_nxt, busy_nxt;
    logic [10:0]     odiv_ext, duty_ext, duty_max;
    logic            cfg_ok;
`ifdef PLL_LOCK_CTRL_PWD_EN
    logic [PW_W-1:0] pwd_cnt, pwd_cnt_nxt;
    logic            from_fail, from_fail_nxt;
`endif

    assign lock_s = lock_sync[1];

    // 11-bit arithmetic so 2*odiv-1 cannot wrap for odiv >= 512
    assign odiv_ext = {1'b0, cfg_odiv};
    assign duty_ext = {1'b0, cfg_duty};
    assign duty_max = {cfg_odiv, 1'b0} - 11'd1;
    assign cfg_ok   = (odiv_ext >= 11'd2) && (duty_ext != 11'd0) && (duty_ext <= duty_max);

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        stable_nxt  = stable_cnt;
        tmo_nxt     = tmo_cnt;
        retry_nxt   = retry_cnt;
        relock_nxt  = relock_cnt;
        odiv_nxt    = dyn_odiv0;
        duty_nxt    = dyn_duty0;
        err_nxt     = 1'b0;
`ifdef PLL_LOCK_CTRL_PWD_EN
        pwd_cnt_nxt   = pwd_cnt;
        from_fail_nxt = from_fail;
`endif
        case (state)
            RST_ASSERT: begin
                if (rst_cnt == RC_LAST) begin
                    state_nxt   = WAIT_LOCK;
                    rst_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                stable_nxt = lock_s ? stable_cnt + 1'b1 : '0;
                tmo_nxt    = tmo_cnt + 1'b1;
                if (stable_nxt == SC_DONE) begin
                    state_nxt  = LOCKED;
                    retry_nxt  = '0;
                    stable_nxt = '0;
                    tmo_nxt    = '0;
                end else if (tmo_nxt == TC_DONE) begin
                    retry_nxt  = retry_cnt + 1'b1;
                    stable_nxt = '0;
                    tmo_nxt    = '0;
                    state_nxt  = (retry_nxt == RT_MAX) ? FAIL : RST_ASSERT;
                end
            end
            LOCKED: begin
                // lock loss outranks a same-cycle request
                if (!lock_s) begin
                    state_nxt  = RST_ASSERT;
                    relock_nxt = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
                end else if (cfg_req) begin
                    if (cfg_ok) begin
                        state_nxt = APPLY;
                        odiv_nxt  = cfg_odiv;
                        duty_nxt  = cfg_duty;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            APPLY: begin
`ifdef PLL_LOCK_CTRL_PWD_EN
                state_nxt     = from_fail ? PWD : RST_ASSERT;
                from_fail_nxt = 1'b0;
`else
                state_nxt = RST_ASSERT;
`endif
            end
            FAIL: begin
                if (cfg_req) begin
                    if (cfg_ok) begin
                        state_nxt = APPLY;
                        retry_nxt = '0;
                        odiv_nxt  = cfg_odiv;
                        duty_nxt  = cfg_duty;
`ifdef PLL_LOCK_CTRL_PWD_EN
                        from_fail_nxt = 1'b1;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
`ifdef PLL_LOCK_CTRL_PWD_EN
            PWD: begin
                if (pwd_cnt == PW_LAST) begin
                    state_nxt   = RST_ASSERT;
                    pwd_cnt_nxt = '0;
                end else begin
                    pwd_cnt_nxt = pwd_cnt + 1'b1;
                end
            end
`endif
            default: state_nxt = RST_ASSERT;
        endcase

        pll_rst_nxt = (state_nxt == RST_ASSERT) || (state_nxt == FAIL);
        busy_nxt    = (state_nxt == RST_ASSERT) || (state_nxt == WAIT_LOCK) || (state_nxt == APPLY);
`ifdef PLL_LOCK_CTRL_PWD_EN
        pll_rst_nxt = pll_rst_nxt || (state_nxt == PWD);
        busy_nxt    = busy_nxt || (state_nxt == PWD);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_STATE;
            lock_sync   <= 2'b00;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            tmo_cnt     <= '0;
            retry_cnt   <= '0;
            relock_cnt  <= 8'd0;
            dyn_odiv0   <= DEF_ODIV;
            dyn_duty0   <= DEF_DUTY;
            pll_rst     <= 1'b1;
            ctrl_locked <= 1'b0;
            cfg_busy    <= 1'b1;
            cfg_ack     <= 1'b0;
            cfg_err     <= 1'b0;
            lock_fail   <= 1'b0;
`ifdef PLL_LOCK_CTRL_PWD_EN
            pwd_cnt     <= '0;
            from_fail   <= 1'b0;
            pll_pwd     <= 1'b1;
`endif
        end else begin
            state       <= state_nxt;
            lock_sync   <= {lock_sync[0], pll_lock};
            rst_cnt     <= rst_cnt_nxt;
            stable_cnt  <= stable_nxt;
            tmo_cnt     <= tmo_nxt;
            retry_cnt   <= retry_nxt;
            relock_cnt  <= relock_nxt;
            dyn_odiv0   <= odiv_nxt;
            dyn_duty0   <= duty_nxt;
            pll_rst     <= pll_rst_nxt;
            ctrl_locked <= (state_nxt == LOCKED);
            cfg_busy    <= busy_nxt;
            cfg_ack     <= (state_nxt == APPLY);
            cfg_err     <= err_nxt;
            lock_fail   <= (state_nxt == FAIL);
`ifdef PLL_LOCK_CTRL_PWD_EN
            pwd_cnt     <= pwd_cnt_nxt;
            from_fail   <= from_fail_nxt;
            pll_pwd     <= (state_nxt == PWD);
`endif
        end
    end

endmodule
